// File: rtl/ddr_traffic_gen_pkg.sv
// Shared types for the DDR4 traffic generator.
// Command direction, generator modes, FSM states and the LFSR step.
package ddr_traffic_gen_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } rw_type;

  typedef enum logic [1:0] {
    SEQ_WR     = 2'd0,
    SEQ_RD     = 2'd1,
    WR_THEN_RD = 2'd2,
    RANDOM     = 2'd3
  } tg_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GAP,
    DRAIN,
    DONE
  } tg_state_e;

  // Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] v
  );
    logic [31:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ LFSR_TAPS;
    return s;
  endfunction

endpackage

// File: rtl/ddr_traffic_gen_fifo.sv
// Expected-read queue for the traffic generator.
// Holds read patterns in issue order; flush is synchronous.
module tg_expect_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign head    = mem[rp[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ddr_traffic_gen.sv
// Traffic generator driving act_cmd/address/data into the DDR4 controller.
// Issues N commands per pass under dev_busy and checks read returns.
module ddr_traffic_gen
  import ddr_traffic_gen_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 64,
  parameter int              CNT_W       = 16,
  parameter int              GAP_CYC     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h2000_0000,
  parameter logic [ADDR_W-1:0] ADDR_STRIDE = 32'h0000_0040,
  parameter logic [31:0]     LFSR_SEED   = 32'hACE1_0001,
  parameter int              Q_DEPTH     = 8,
  parameter int              DRAIN_TO    = 1024
) (
  input  logic              clock_n,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  num_txn,
  input  logic              dev_busy,
  output logic              act_cmd,
  output logic [ADDR_W-1:0] physical_addr,
  output logic [DATA_W-1:0] data_wr,
  output rw_type            rw,
  input  logic              rd_data_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  txn_count
);

  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int DW = $clog2(DRAIN_TO + 1);

  tg_state_e         state;
  tg_state_e         state_nx;
  tg_mode_e          mode_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  idx;
  logic              pass2;
  logic [ADDR_W-1:0] nxt_addr;
  logic [31:0]       lfsr;
  logic [31:0]       lfsr_nx;
  logic [GW-1:0]     gap_cnt;
  logic [DW-1:0]     drain_cnt;

  logic              start_ok;
  logic              can_issue;
  logic              gap_end;
  logic              pass_done;
  logic              more_pass;
  logic              drain_exp;
  logic              done_nx;
  logic [ADDR_W-1:0] cmd_addr;
  rw_type            cmd_rw;

  logic              q_push;
  logic              q_pop;
  logic              q_full;
  logic              q_empty;
  logic [DATA_W-1:0] q_head;
  logic              mism;
  logic              unexp;
  logic [1:0]        err_inc;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [1:0]       b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign start_ok  = start && (state == IDLE || state == DONE);
  assign can_issue = (state == ISSUE) && !dev_busy && !q_full;
  assign gap_end   = (state == GAP) &&
                     (gap_cnt == GW'(GAP_CYC - 1));
  assign pass_done = (idx == num_q);
  assign more_pass = (mode_q == WR_THEN_RD) && !pass2;
  assign drain_exp = (state == DRAIN) && !q_empty &&
                     (drain_cnt == DW'(DRAIN_TO - 1));
  assign busy      = (state == ISSUE) || (state == GAP) ||
                     (state == DRAIN);
  assign lfsr_nx   = lfsr_step(lfsr);

  always_ff @(posedge clock_n or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nx = (num_txn == '0) ? DONE : ISSUE;
      end
      ISSUE: if (can_issue) state_nx = GAP;
      GAP: begin
        if (gap_end)
          state_nx = (!pass_done || more_pass) ? ISSUE : DRAIN;
      end
      DRAIN: if (q_empty || drain_exp) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  assign done_nx = (state_nx == DONE) &&
                   ((state != DONE) || start_ok);

  always_comb begin
    cmd_rw   = READ;
    cmd_addr = nxt_addr;
    unique case (1'b1)
      mode_q == SEQ_WR:     cmd_rw = WRITE;
      mode_q == SEQ_RD:     cmd_rw = READ;
      mode_q == WR_THEN_RD: cmd_rw = pass2 ? READ : WRITE;
      default: begin
        cmd_rw   = rw_type'(lfsr_nx[0]);
        cmd_addr = ADDR_W'(lfsr_nx) & ~(ADDR_STRIDE - 1'b1);
      end
    endcase
  end

  // Only second-pass reads of WR_THEN_RD carry an expected pattern
  assign q_push  = can_issue && (mode_q == WR_THEN_RD) && pass2;
  assign q_pop   = rd_data_valid && !q_empty;
  assign mism    = q_pop && (rd_data != q_head);
  assign unexp   = rd_data_valid && q_empty &&
                   (mode_q == WR_THEN_RD);
  assign err_inc = {1'b0, mism | unexp} + {1'b0, drain_exp};

  tg_expect_fifo #(
    .DEPTH (Q_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (clock_n),
    .rst_n (reset_n),
    .flush (start_ok),
    .push  (q_push),
    .pop   (q_pop),
    .wdata ({cmd_addr, cmd_addr}),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clock_n or negedge reset_n) begin
    if (!reset_n) begin
      act_cmd       <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_count     <= '0;
      txn_count     <= '0;
      physical_addr <= '0;
      data_wr       <= '0;
      rw            <= READ;
      mode_q        <= SEQ_WR;
      num_q         <= '0;
      idx           <= '0;
      pass2         <= 1'b0;
      nxt_addr      <= BASE_ADDR;
      lfsr          <= LFSR_SEED;
      gap_cnt       <= '0;
      drain_cnt     <= '0;
    end else begin
      act_cmd <= can_issue;
      done    <= done_nx;
      if (start_ok) begin
        mode_q    <= tg_mode_e'(mode);
        num_q     <= num_txn;
        idx       <= '0;
        pass2     <= 1'b0;
        nxt_addr  <= BASE_ADDR;
        txn_count <= '0;
        err_count <= '0;
        error     <= 1'b0;
      end else begin
        if (can_issue) begin
          physical_addr <= cmd_addr;
          data_wr       <= {cmd_addr, cmd_addr};
          rw            <= cmd_rw;
          txn_count     <= txn_count + 1'b1;
          idx           <= idx + 1'b1;
          nxt_addr      <= nxt_addr + ADDR_STRIDE;
          gap_cnt       <= '0;
          if (mode_q == RANDOM) lfsr <= lfsr_nx;
        end
        if (state == GAP) begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_end && pass_done && more_pass) begin
            pass2    <= 1'b1;
            idx      <= '0;
            nxt_addr <= BASE_ADDR;
          end
        end
        if (state != DRAIN) drain_cnt <= '0;
        else                drain_cnt <= drain_cnt + 1'b1;
        if (err_inc != 2'd0) begin
          error     <= 1'b1;
          err_count <= sat_add(err_count, err_inc);
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_traffic_gen.sv
// Randomized scoreboard bench for ddr_traffic_gen.
// A plan model queues expected commands; a monitor checks each act_cmd.
module tb_ddr_traffic_gen;
  import ddr_traffic_gen_pkg::*;

  localparam logic [31:0] BASE   = 32'h2000_0000;
  localparam logic [31:0] STRIDE = 32'h0000_0040;
  localparam logic [31:0] SEED   = 32'hACE1_0001;
  localparam logic [31:0] TAPS   = 32'h8020_0003;

  logic        clock_n = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] num_txn = '0;
  logic        dev_busy = 1'b0;
  logic        rd_data_valid = 1'b0;
  logic [63:0] rd_data = '0;
  logic        act_cmd;
  logic [31:0] physical_addr;
  logic [63:0] data_wr;
  rw_type      rw;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] err_count;
  logic [15:0] txn_count;

  ddr_traffic_gen dut (
    .clock_n       (clock_n),
    .reset_n       (reset_n),
    .start         (start),
    .mode          (mode),
    .num_txn       (num_txn),
    .dev_busy      (dev_busy),
    .act_cmd       (act_cmd),
    .physical_addr (physical_addr),
    .data_wr       (data_wr),
    .rw            (rw),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_count     (err_count),
    .txn_count     (txn_count)
  );

  always #5 clock_n = ~clock_n;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [63:0] data;
  } cmd_t;

  typedef struct {
    int          due;
    logic [63:0] d;
  } ret_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  cmd_t        exp_q[$];
  ret_t        ret_q[$];
  logic [63:0] mem[logic [31:0]];
  logic [31:0] m_lfsr = SEED;
  logic [31:0] last_addr = '0;
  logic        busy_smp = 1'b0;
  int          last_act = -1;
  int          strict = 0;
  int          act_seen = 0;
  int          dimm_lat = 3;
  int          withhold = 0;
  int          release_n = 0;
  int          rd_idx = 0;
  int          corrupt_idx = -1;
  int          done_k = 0;

  always @(posedge clock_n) begin
    cyc      <= cyc + 1;
    busy_smp <= dev_busy;
  end

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Scoreboard monitor: every act_cmd pops one expected command
  always @(negedge clock_n) begin
    cmd_t e;
    if (reset_n && act_cmd) begin
      act_seen++;
      check("act_while_busy", busy_smp, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_act", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("addr", physical_addr, e.addr);
        check("rw", rw, e.rw);
        if (e.rw == WRITE) check("data_wr", data_wr, e.data);
      end
      if (strict != 0 && last_act >= 0)
        check("spacing", cyc - last_act, 9);
      last_act  = cyc;
      last_addr = physical_addr;
    end else if (reset_n && dev_busy && busy) begin
      check("hold_addr", physical_addr, last_addr);
    end
  end

  // DIMM model: stores writes, returns reads after dimm_lat cycles
  always @(negedge clock_n) begin
    ret_t r;
    if (reset_n && act_cmd) begin
      if (rw == WRITE) begin
        mem[physical_addr] = data_wr;
      end else begin
        if (mem.exists(physical_addr)) r.d = mem[physical_addr];
        else r.d = 64'hDEAD_BEEF_0000_0001;
        if (rd_idx == corrupt_idx) r.d[0] = ~r.d[0];
        rd_idx++;
        r.due = cyc + dimm_lat;
        ret_q.push_back(r);
      end
    end
  end

  always @(posedge clock_n) begin
    #1;
    rd_data_valid = 1'b0;
    if (ret_q.size() > 0 && ret_q[0].due <= cyc &&
        (withhold == 0 || release_n > 0)) begin
      if (withhold != 0) release_n--;
      rd_data       = ret_q[0].d;
      rd_data_valid = 1'b1;
      void'(ret_q.pop_front());
    end
  end

  task automatic plan(input int md, input int n);
    logic [31:0] a;
    cmd_t        c;
    for (int p = 0; p < ((md == 2) ? 2 : 1); p++) begin
      for (int i = 0; i < n; i++) begin
        a = BASE + 32'(i) * STRIDE;
        if (md == 3) begin
          m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 32'h0);
          a      = m_lfsr & ~(STRIDE - 32'h1);
          c.rw   = m_lfsr[0];
        end else begin
          c.rw = (md == 1 || (md == 2 && p == 1)) ? READ : WRITE;
        end
        c.addr = a;
        c.data = {a, a};
        exp_q.push_back(c);
      end
    end
  endtask

  task automatic run(input int md, input int n,
                     input int exp_err, input int done_lat);
    int got;
    got = 0;
    plan(md, n);
    rd_idx   = 0;
    last_act = -1;
    act_seen = 0;
    @(posedge clock_n); #1;
    mode    = 2'(md);
    num_txn = 16'(n);
    start   = 1'b1;
    @(posedge clock_n); #1;
    start = 1'b0;
    for (int k = 0; k < n * 40 + 2000 && got == 0; k++) begin
      @(negedge clock_n);
      if (done) begin
        got    = 1;
        done_k = k;
      end
    end
    check("done_seen", got, 1);
    if (got != 0) begin
      if (done_lat >= 0) check("done_lat", cyc - last_act, done_lat);
      check("txn_count", txn_count, (md == 2) ? 2 * n : n);
      check("err_count", err_count, exp_err);
      check("error", error, exp_err != 0);
      check("busy_at_done", busy, 0);
      check("cmds_left", exp_q.size(), 0);
      @(negedge clock_n);
      check("done_pulse", done, 0);
    end
    exp_q.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_act"}, act_cmd, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_errcnt"}, err_count, 0);
    check({tag, "_txn"}, txn_count, 0);
    check({tag, "_addr"}, physical_addr, 0);
    check({tag, "_data"}, data_wr, 0);
    check({tag, "_rw"}, rw, READ);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int md;
    int n;
    int got;
    repeat (3) @(posedge clock_n);
    @(negedge clock_n);
    check_reset("rst");
    reset_n = 1'b1;

    strict = 1;
    run(0, 4, 0, 9);

    run(2, 3, 0, -1);

    corrupt_idx = 1;
    run(2, 3, 1, -1);
    corrupt_idx = -1;

    strict = 0;
    fork
      run(0, 6, 0, -1);
      begin
        got = 0;
        for (int k = 0; k < 400 && got == 0; k++) begin
          @(negedge clock_n);
          if (act_seen >= 2) got = 1;
        end
        check("busy_window_reached", got, 1);
        @(posedge clock_n); #1;
        dev_busy = 1'b1;
        repeat (20) @(posedge clock_n);
        #1;
        dev_busy = 1'b0;
        mode     = 2'd3;
        num_txn  = 16'd1;
        start    = 1'b1;
        @(posedge clock_n); #1;
        start = 1'b0;
      end
    join

    run(1, 5, 0, -1);

    run(0, 0, 0, -1);
    check("zero_done_lat", done_k, 0);

    run(3, 5, 0, -1);

    plan(0, 4);
    @(posedge clock_n); #1;
    mode    = 2'd0;
    num_txn = 16'd4;
    start   = 1'b1;
    @(posedge clock_n); #1;
    start = 1'b0;
    repeat (4) @(negedge clock_n);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("async_rst");
    exp_q.delete();
    ret_q.delete();
    m_lfsr = SEED;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock_n);
      check("no_done_in_rst", done, 0);
    end
    reset_n = 1'b1;
    repeat (12) begin
      @(negedge clock_n);
      check("no_done_after_rst", done, 0);
    end

    run(3, 6, 0, -1);

    strict = 1;
    for (int it = 0; it < 4; it++) begin
      md       = int'($urandom_range(0, 3));
      n        = int'($urandom_range(1, 6));
      dimm_lat = int'($urandom_range(1, 5));
      run(md, n, 0, -1);
    end
    strict   = 0;
    dimm_lat = 3;

    withhold  = 1;
    release_n = 0;
    fork
      run(2, 10, 1, -1);
      begin
        got = 0;
        for (int k = 0; k < 800 && got == 0; k++) begin
          @(negedge clock_n);
          if (txn_count >= 16'd18) got = 1;
        end
        check("stall_reached", got, 1);
        repeat (50) @(negedge clock_n);
        check("stall_q_full", txn_count, 18);
        release_n = 2;
      end
    join
    ret_q.delete();
    withhold = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
